// File: rtl/rv32ima_pkg.sv
// Shared types for the memory arbiter: load/store width encoding (funct3) and
// arbiter state encoding.
package rv32ima_pkg;

    localparam int LDST_WIDTH_W = 3;

    typedef enum logic [LDST_WIDTH_W-1:0] {
        LDST_B  = 3'b000,
        LDST_H  = 3'b001,
        LDST_W  = 3'b010,
        LDST_BU = 3'b100,
        LDST_HU = 3'b101
    } ldst_width_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t DACC = 2'd1;
    localparam arb_state_t IACC = 2'd2;

endpackage

// File: rtl/ldst_align.sv
// Combinational byte-lane logic: store lane replication and strobes, load
// byte/half extraction with sign/zero extension, and misalignment detection.
module ldst_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]              offset,
    input  logic [LDST_WIDTH_W-1:0] width,
    input  logic [31:0]             store_data,
    input  logic [31:0]             load_word,
    output logic [3:0]              strb,
    output logic [31:0]             store_lanes,
    output logic [31:0]             load_data,
    output logic                    misalign
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_byte = load_word[{offset, 3'b000} +: 8];
    assign load_half = offset[1] ? load_word[31:16] : load_word[15:0];

    // width[2] selects zero extension (LBU/LHU); width[1:0] selects the size.
    always_comb begin
        strb        = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
        misalign    = 1'b0;
        case (width[1:0])
            2'b00: begin
                strb        = 4'b0001 << offset;
                store_lanes = {4{store_data[7:0]}};
                load_data   = width[2] ? {24'b0, load_byte}
                                       : {{24{load_byte[7]}}, load_byte};
            end
            2'b01: begin
                strb        = 4'b0011 << offset;
                store_lanes = {2{store_data[15:0]}};
                load_data   = width[2] ? {16'b0, load_half}
                                       : {{16{load_half[15]}}, load_half};
                misalign    = offset[0];
            end
            default: begin
                misalign    = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto a single-port,
// variable-latency RAM, with data priority and a per-transaction timeout.
module mem_arbiter
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    imem_ren,
    input  logic [ADDR_W-1:0]       imem_addr,
    output logic [31:0]             imem_load,
    output logic                    ihit,
    input  logic                    dmem_ren,
    input  logic                    dmem_wen,
    input  logic [ADDR_W-1:0]       dmem_addr,
    input  logic [31:0]             dmem_store,
    input  logic [LDST_WIDTH_W-1:0] dmem_width,
    output logic [31:0]             dmem_load,
    output logic                    dhit,
    output logic                    bus_err,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [31:0]             ram_store,
    output logic [3:0]              ram_strb,
    input  logic [31:0]             ram_load,
    input  logic                    ram_ready,
    output arb_state_t              dbg_state
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                state;
    arb_state_t                next_state;
    logic [TCNT_W-1:0]         tcnt;
    logic [ADDR_W-1:0]         req_addr;
    logic [LDST_WIDTH_W-1:0]   req_width;
    logic [31:0]               req_store;
    logic                      req_write;

    logic        in_dacc, in_iacc, d_live;
    logic        timeout, mis, d_done, i_done, done, dacc_go;
    logic [3:0]  al_strb;
    logic [31:0] al_store, al_load;
    logic        al_mis;

    ldst_align u_align (
        .offset      (req_addr[1:0]),
        .width       (req_width),
        .store_data  (req_store),
        .load_word   (ram_load),
        .strb        (al_strb),
        .store_lanes (al_store),
        .load_data   (al_load),
        .misalign    (al_mis)
    );

    assign in_dacc = (state == DACC);
    assign in_iacc = (state == IACC);
    assign d_live  = dmem_ren | dmem_wen;
    assign mis     = in_dacc & al_mis;
    assign timeout = (in_dacc | in_iacc) & ~ram_ready & ~mis & (tcnt == TCNT_MAX);
    assign d_done  = in_dacc & (ram_ready | timeout | mis);
    assign i_done  = in_iacc & (ram_ready | timeout);
    assign done    = d_done | i_done;
    assign dacc_go = in_dacc & ~mis & ~timeout;

    // A hit also requires the request to still be live, so a flushed request
    // completes on the RAM side without reporting back.
    assign dhit      = d_done & d_live;
    assign ihit      = i_done & imem_ren;
    assign bus_err   = (dhit & (timeout | mis)) | (ihit & timeout);
    assign dmem_load = (dhit & ram_ready & ~mis & ~req_write) ? al_load : 32'b0;
    assign imem_load = (ihit & ram_ready) ? ram_load : 32'b0;

    assign ram_ren   = (dacc_go & ~req_write) | (in_iacc & ~timeout);
    assign ram_wen   = dacc_go & req_write;
    assign ram_addr  = (ram_ren | ram_wen) ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
    assign ram_store = ram_wen ? al_store : 32'b0;
    assign ram_strb  = ram_wen ? al_strb : 4'b0;
    assign dbg_state = state;

    // The request just retired is still asserted in its completion cycle, so
    // only the other port counts as pending when choosing the next access.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_live)        next_state = DACC;
                else if (imem_ren) next_state = IACC;
            end
            DACC: begin
                if (d_done)        next_state = imem_ren ? IACC : IDLE;
            end
            IACC: begin
                if (i_done)        next_state = d_live ? DACC : IDLE;
            end
            default:               next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            tcnt      <= '0;
            req_addr  <= '0;
            req_width <= '0;
            req_store <= '0;
            req_write <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE || done) tcnt <= '0;
            else                       tcnt <= tcnt + TCNT_W'(1);
            if (state == IDLE || done) begin
                if (next_state == DACC) begin
                    req_addr  <= dmem_addr;
                    req_width <= dmem_width;
                    req_store <= dmem_store;
                    req_write <= dmem_wen;
                end else begin
                    req_addr  <= imem_addr;
                    req_width <= LDST_W;
                    req_store <= '0;
                    req_write <= 1'b0;
                end
            end
        end
    end

endmodule
